// File: rtl/logic_cell_pkg.sv
// Shared types and config-word field helpers for the fracturable logic cell.
// Word layout from LSB: LUT mask, fracture flag, two bypass bits, two init bits.
package logic_cell_pkg;

  typedef enum logic [0:0] {
    UNCONFIGURED = 1'b0,
    RUNNING      = 1'b1
  } cell_state_t;

  function automatic int config_bits(input int k);
    return (1 << k) + 5;
  endfunction

  // The mask field always starts at bit 0, so only its MSB needs a helper.
  function automatic int mask_msb(input int k);
    return (1 << k) - 1;
  endfunction

  function automatic int fracture_pos(input int k);
    return (1 << k);
  endfunction

  function automatic int bypass_lsb(input int k);
    return (1 << k) + 1;
  endfunction

  function automatic int init_lsb(input int k);
    return (1 << k) + 3;
  endfunction

endpackage

// File: rtl/logic_cell_frac_if.sv
// Signal bundle of one logic cell: config chain, commit/capture, LUT I/O and debug taps.
// Handshake: commit and capture are single-cycle strobes sampled at posedge; there is no
// ready, so a refused commit is signalled by o_CommitRejected in the following cycle.
interface logic_cell_frac_if
  import logic_cell_pkg::*;
#(
  parameter int K = 4
);
  localparam int CW = $clog2(config_bits(K) + 1);

  logic          i_ConfigShiftEnable;
  logic          i_ConfigShiftInput;
  logic          o_ConfigShiftOutput;
  logic          i_ConfigCommit;
  logic          i_ConfigCapture;
  logic          o_CommitRejected;
  logic          o_Configured;
  logic          i_ClockEnable;
  logic [K-1:0]  i_LookupTableInputs;
  logic [1:0]    o_Output;
  cell_state_t   dbg_state;
  logic [CW-1:0] dbg_count;

  modport master (
    output i_ConfigShiftEnable, i_ConfigShiftInput, i_ConfigCommit, i_ConfigCapture,
           i_ClockEnable, i_LookupTableInputs,
    input  o_ConfigShiftOutput, o_CommitRejected, o_Configured, o_Output,
           dbg_state, dbg_count
  );

  modport slave (
    input  i_ConfigShiftEnable, i_ConfigShiftInput, i_ConfigCommit, i_ConfigCapture,
           i_ClockEnable, i_LookupTableInputs,
    output o_ConfigShiftOutput, o_CommitRejected, o_Configured, o_Output,
           dbg_state, dbg_count
  );
endinterface

// File: rtl/lut_fracturable.sv
// Combinational 2^K-entry LUT, usable as one K-input LUT or two (K-1)-input LUTs.
module lut_fracturable #(
  parameter int K = 4
) (
  input  logic [(1<<K)-1:0] mask,
  input  logic              fracture,
  input  logic [K-1:0]      addr,
  output logic              lut0,
  output logic              lut1
);
  logic [K-1:0] addr0;
  logic [K-1:0] addr1;

  // In fractured mode the top address bit selects the half instead of the input.
  always_comb begin
    addr0 = fracture ? {1'b0, addr[K-2:0]} : addr;
    addr1 = {1'b1, addr[K-2:0]};
    lut0  = mask[addr0];
    lut1  = fracture ? mask[addr1] : 1'b0;
  end
endmodule

// File: rtl/logic_cell_frac.sv
// Fracturable logic cell: shadow config chain with atomic commit/readback,
// a two-output LUT and a bypassable output flip-flop per output.
module logic_cell_frac
  import logic_cell_pkg::*;
#(
  parameter int LUT_INPUTS  = 4,
  parameter int CONFIG_BITS = config_bits(LUT_INPUTS)
) (
  input  logic              i_Clock,
  input  logic              i_Reset_n,
  logic_cell_frac_if.slave  bus
);
  localparam int CW   = $clog2(CONFIG_BITS + 1);
  localparam int MMSB = mask_msb(LUT_INPUTS);
  localparam int FRAC = fracture_pos(LUT_INPUTS);
  localparam int BYP  = bypass_lsb(LUT_INPUTS);
  localparam int INIT = init_lsb(LUT_INPUTS);
  localparam logic [CW-1:0] FULL = CW'(CONFIG_BITS);

  logic [CONFIG_BITS-1:0] shadow_q, shadow_d;
  logic [CONFIG_BITS-1:0] active_q, active_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  cell_state_t            state_q, state_d;
  logic [1:0]             ff_q, ff_d;
  logic                   rej_q, rej_d;
  logic [1:0]             lut;
  logic                   full;
  logic                   commit_ok;
  logic                   capture_ok;

  lut_fracturable #(.K(LUT_INPUTS)) u_lut (
    .mask     (active_q[MMSB:0]),
    .fracture (active_q[FRAC]),
    .addr     (bus.i_LookupTableInputs),
    .lut0     (lut[0]),
    .lut1     (lut[1])
  );

  // Commit outranks capture; capture outranks shift.
  always_comb begin
    shadow_d   = shadow_q;
    active_d   = active_q;
    cnt_d      = cnt_q;
    state_d    = state_q;
    ff_d       = ff_q;
    rej_d      = 1'b0;
    full       = (cnt_q == FULL);
    commit_ok  = bus.i_ConfigCommit && full;
    capture_ok = bus.i_ConfigCapture && !bus.i_ConfigCommit;

    if (state_q == RUNNING && bus.i_ClockEnable) ff_d = lut;

    if (capture_ok) begin
      shadow_d = active_q;
      cnt_d    = FULL;
    end else if (bus.i_ConfigShiftEnable) begin
      shadow_d = {shadow_q[CONFIG_BITS-2:0], bus.i_ConfigShiftInput};
      if (!full) cnt_d = cnt_q + 1'b1;
    end

    if (commit_ok) begin
      active_d = shadow_q;
      ff_d     = shadow_q[INIT +: 2];
      state_d  = RUNNING;
      cnt_d    = bus.i_ConfigShiftEnable ? CW'(1) : '0;
    end else if (bus.i_ConfigCommit) begin
      rej_d = 1'b1;
    end

    if (state_d == UNCONFIGURED) ff_d = '0;
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      shadow_q <= '0;
      active_q <= '0;
      cnt_q    <= '0;
      state_q  <= UNCONFIGURED;
      ff_q     <= '0;
      rej_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      ff_q     <= ff_d;
      rej_q    <= rej_d;
    end
  end

  always_comb begin
    bus.o_Output = '0;
    if (state_q == RUNNING) begin
      for (int n = 0; n < 2; n++)
        bus.o_Output[n] = active_q[BYP+n] ? lut[n] : ff_q[n];
    end
  end

  assign bus.o_ConfigShiftOutput = shadow_q[CONFIG_BITS-1];
  assign bus.o_CommitRejected    = rej_q;
  assign bus.o_Configured        = (state_q == RUNNING);
  assign bus.dbg_state           = state_q;
  assign bus.dbg_count           = cnt_q;
endmodule

// File: tb/tb_logic_cell_frac.sv
// Self-checking bench for logic_cell_frac with K=4 (21-bit config word).
module tb_logic_cell_frac;
  import logic_cell_pkg::*;

  localparam int K  = 4;
  localparam int CB = 21;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  logic [1:0] exp_q[$];

  logic_cell_frac_if #(.K(K)) bus ();

  logic_cell_frac #(.LUT_INPUTS(K)) dut (
    .i_Clock   (clk),
    .i_Reset_n (rst_n),
    .bus       (bus)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [15:0] mask;
    logic        frac;
    logic [1:0]  byp;
    logic [1:0]  init;
    logic [3:0]  addr;
    logic [1:0]  exp;
  } vec_t;

  vec_t vecs[10];

  function automatic logic [CB-1:0] mk(logic [15:0] mask, logic frac, logic [1:0] byp,
                                      logic [1:0] init);
    return {init, byp, frac, mask};
  endfunction

  // Reference LUT used for random configurations.
  function automatic logic [1:0] model(logic [15:0] mask, logic frac, logic [3:0] a);
    logic [3:0] lo_idx;
    logic [3:0] hi_idx;
    lo_idx = frac ? {1'b0, a[2:0]} : a;
    hi_idx = {1'b1, a[2:0]};
    return {frac ? mask[hi_idx] : 1'b0, mask[lo_idx]};
  endfunction

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_bits(input logic [CB-1:0] w, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) begin
      bus.i_ConfigShiftEnable = 1'b1;
      bus.i_ConfigShiftInput  = w[i];
      tick();
    end
    bus.i_ConfigShiftEnable = 1'b0;
    bus.i_ConfigShiftInput  = 1'b0;
  endtask

  task automatic commit();
    bus.i_ConfigCommit = 1'b1;
    tick();
    bus.i_ConfigCommit = 1'b0;
  endtask

  task automatic load(input logic [CB-1:0] w);
    shift_bits(w, CB-1, 0);
    commit();
  endtask

  // Scoreboard
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic sb_check(input string name, input logic [1:0] act);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got %0h expected queue entry (queue empty)", name, act);
    end else begin
      check(name, {30'd0, act}, {30'd0, exp_q.pop_front()});
    end
  endtask

  task automatic readback(input string name, input logic [CB-1:0] w);
    for (int i = CB - 1; i >= 0; i--) begin
      exp_q.push_back({1'b0, w[i]});
      sb_check(name, {1'b0, bus.o_ConfigShiftOutput});
      bus.i_ConfigShiftEnable = 1'b1;
      bus.i_ConfigShiftInput  = 1'b0;
      tick();
    end
    bus.i_ConfigShiftEnable = 1'b0;
  endtask

  logic [CB-1:0] w_new;
  logic [15:0]   r_mask;
  logic          r_frac;
  logic [3:0]    r_addr;

  initial begin
    vecs[0] = '{16'h8000, 1'b0, 2'b11, 2'b00, 4'hF, 2'b01};
    vecs[1] = '{16'h8000, 1'b0, 2'b11, 2'b00, 4'h7, 2'b00};
    vecs[2] = '{16'hFF00, 1'b1, 2'b11, 2'b00, 4'h3, 2'b10};
    vecs[3] = '{16'hFF00, 1'b1, 2'b11, 2'b00, 4'hB, 2'b10};
    vecs[4] = '{16'h00F0, 1'b0, 2'b11, 2'b00, 4'h5, 2'b01};
    vecs[5] = '{16'h0001, 1'b1, 2'b11, 2'b00, 4'h8, 2'b01};
    vecs[6] = '{16'h0100, 1'b1, 2'b11, 2'b00, 4'h0, 2'b10};
    vecs[7] = '{16'hA5A5, 1'b0, 2'b11, 2'b00, 4'h2, 2'b01};
    vecs[8] = '{16'hFFFF, 1'b1, 2'b01, 2'b00, 4'h0, 2'b01};
    vecs[9] = '{16'hFFFF, 1'b0, 2'b10, 2'b00, 4'h0, 2'b00};

    rst_n                   = 1'b0;
    bus.i_ConfigShiftEnable = 1'b0;
    bus.i_ConfigShiftInput  = 1'b0;
    bus.i_ConfigCommit      = 1'b0;
    bus.i_ConfigCapture     = 1'b0;
    bus.i_ClockEnable       = 1'b0;
    bus.i_LookupTableInputs = '0;
    tick();
    tick();
    rst_n = 1'b1;

    // Reset state
    check("rst_out", {30'd0, bus.o_Output}, 0);
    check("rst_configured", {31'd0, bus.o_Configured}, 0);
    check("rst_rejected", {31'd0, bus.o_CommitRejected}, 0);
    check("rst_shift_out", {31'd0, bus.o_ConfigShiftOutput}, 0);
    check("rst_count", {27'd0, bus.dbg_count}, 0);

    // Commit with an empty chain is refused for exactly one cycle
    commit();
    check("empty_commit_rej", {31'd0, bus.o_CommitRejected}, 1);
    check("empty_commit_cfg", {31'd0, bus.o_Configured}, 0);
    check("empty_commit_out", {30'd0, bus.o_Output}, 0);
    tick();
    check("empty_commit_rej_clr", {31'd0, bus.o_CommitRejected}, 0);

    // Table-driven combinational vectors
    foreach (vecs[v]) begin
      bus.i_LookupTableInputs = vecs[v].addr;
      load(mk(vecs[v].mask, vecs[v].frac, vecs[v].byp, vecs[v].init));
      exp_q.push_back(vecs[v].exp);
      sb_check($sformatf("vec%0d", v), bus.o_Output);
    end
    check("vec_configured", {31'd0, bus.o_Configured}, 1);

    // Random masks: change the address without a clock edge
    for (int r = 0; r < 5; r++) begin
      r_mask = 16'($urandom_range(0, 16'hFFFF));
      r_frac = 1'($urandom_range(0, 1));
      load(mk(r_mask, r_frac, 2'b11, 2'b00));
      for (int j = 0; j < 4; j++) begin
        r_addr = 4'($urandom_range(0, 15));
        bus.i_LookupTableInputs = r_addr;
        exp_q.push_back(model(r_mask, r_frac, r_addr));
        #1;
        sb_check("rand_comb", bus.o_Output);
      end
    end

    // Registered path: init values, hold with CE low, load with CE high
    bus.i_LookupTableInputs = 4'h0;
    load(mk(16'hFF00, 1'b1, 2'b00, 2'b11));
    check("reg_init", {30'd0, bus.o_Output}, 2'b11);
    tick();
    check("reg_hold", {30'd0, bus.o_Output}, 2'b11);
    bus.i_ClockEnable = 1'b1;
    tick();
    check("reg_load", {30'd0, bus.o_Output}, 2'b10);
    bus.i_ClockEnable = 1'b0;

    // Partial reload while running is refused, completion is accepted
    w_new = mk(16'h8000, 1'b0, 2'b11, 2'b00);
    bus.i_LookupTableInputs = 4'hF;
    shift_bits(w_new, CB-1, CB-10);
    check("partial_count", {27'd0, bus.dbg_count}, 10);
    commit();
    check("partial_rej", {31'd0, bus.o_CommitRejected}, 1);
    check("partial_out", {30'd0, bus.o_Output}, 2'b10);
    shift_bits(w_new, CB-11, 0);
    check("partial_out_pre", {30'd0, bus.o_Output}, 2'b10);
    commit();
    check("reload_out", {30'd0, bus.o_Output}, 2'b01);
    check("reload_count", {27'd0, bus.dbg_count}, 0);

    // Readback of the active word, then capture together with shift
    bus.i_ConfigCapture = 1'b1;
    tick();
    bus.i_ConfigCapture = 1'b0;
    check("capture_count", {27'd0, bus.dbg_count}, CB);
    readback("readback", w_new);
    check("count_saturated", {27'd0, bus.dbg_count}, CB);
    bus.i_ConfigCapture     = 1'b1;
    bus.i_ConfigShiftEnable = 1'b1;
    bus.i_ConfigShiftInput  = 1'b1;
    tick();
    bus.i_ConfigCapture     = 1'b0;
    bus.i_ConfigShiftEnable = 1'b0;
    readback("capture_shift", w_new);

    // Commit beats capture: counter clears instead of filling
    bus.i_ConfigCapture = 1'b1;
    commit();
    bus.i_ConfigCapture = 1'b0;
    check("commit_capture_count", {27'd0, bus.dbg_count}, 0);

    // Commit with shift uses the pre-edge shadow and leaves one bit counted
    w_new = mk(16'h00F0, 1'b0, 2'b11, 2'b00);
    shift_bits(w_new, CB-1, 0);
    bus.i_ConfigShiftEnable = 1'b1;
    bus.i_ConfigShiftInput  = 1'b1;
    commit();
    bus.i_ConfigShiftEnable = 1'b0;
    check("commit_shift_count", {27'd0, bus.dbg_count}, 1);
    bus.i_LookupTableInputs = 4'h5;
    #1;
    check("commit_shift_out5", {30'd0, bus.o_Output}, 2'b01);
    bus.i_LookupTableInputs = 4'h0;
    #1;
    check("commit_shift_out0", {30'd0, bus.o_Output}, 2'b00);

    // Reset mid-shift while running beats shift and commit
    bus.i_LookupTableInputs = 4'h5;
    shift_bits({CB{1'b1}}, CB-1, CB-5);
    rst_n                   = 1'b0;
    bus.i_ConfigShiftEnable = 1'b1;
    bus.i_ConfigShiftInput  = 1'b1;
    bus.i_ConfigCommit      = 1'b1;
    tick();
    bus.i_ConfigShiftEnable = 1'b0;
    bus.i_ConfigCommit      = 1'b0;
    rst_n                   = 1'b1;
    check("midrst_out", {30'd0, bus.o_Output}, 0);
    check("midrst_configured", {31'd0, bus.o_Configured}, 0);
    check("midrst_count", {27'd0, bus.dbg_count}, 0);
    check("midrst_shift_out", {31'd0, bus.o_ConfigShiftOutput}, 0);
    check("midrst_rej", {31'd0, bus.o_CommitRejected}, 0);
    check("midrst_state", {31'd0, bus.dbg_state}, {31'd0, UNCONFIGURED});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
